// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner: hex decode, per-digit blanking, decimal points,
// refresh prescaler, inter-digit ghost blanking and frame-aligned double-buffered data.
module seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   dout,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int   IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   PW  = $clog2(PRESCALE);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic                    load_pend;
  logic [4*NUM_DIGITS-1:0] sh_dig;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_dp;

  logic                    slot_end;
  logic                    frame_end;
  logic                    in_blank;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_dp;
  logic                    lit;
  logic [6:0]              hex_seg;
  logic [NUM_DIGITS-1:0]   dout_nx;
  logic [6:0]              seg_nx;
  logic                    dp_nx;

  assign slot_end  = (pcnt == PW'(PRESCALE - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      idx  <= frame_end ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // A load seen on the boundary edge itself is taken immediately; otherwise it waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pend <= 1'b0;
      sh_dig    <= '0;
      sh_blank  <= '1;
      sh_dp     <= '0;
    end else if (frame_end) begin
      load_pend <= 1'b0;
      if (load_pend || load) begin
        sh_dig   <= digits_in;
        sh_blank <= blank_in;
        sh_dp    <= dp_in;
      end
    end else if (load) begin
      load_pend <= 1'b1;
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (pcnt < PW'(BLANK_CYCLES));
    end
  endgenerate

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b1;
    cur_dp    = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = sh_dig[4*i +: 4];
        cur_blank = sh_blank[i];
        cur_dp    = sh_dp[i];
      end
    end
  end

  always_comb begin
    hex_seg = '0;
    case (cur_nib)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      4'hF: hex_seg = 7'h71;
      default: hex_seg = '0;
    endcase
  end

  assign lit = !in_blank && !cur_blank;

  always_comb begin
    dout_nx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dout_nx[i] = lit && (idx == IW'(i));
    end
    seg_nx = lit ? hex_seg : '0;
    dp_nx  = lit && cur_dp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= {NUM_DIGITS{POL}};
      seg        <= {7{POL}};
      dp         <= POL;
      frame_done <= 1'b0;
    end else begin
      dout       <= dout_nx ^ {NUM_DIGITS{POL}};
      seg        <= seg_nx ^ {7{POL}};
      dp         <= dp_nx ^ POL;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan at its default configuration (4 digits, prescale 4,
// one ghost-blank cycle, active-low pins).
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  dout;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int tests_run = 0;
  int fails = 0;
  int k = 0;

  always #5 clk = ~clk;

  seg_scan #(
    .NUM_DIGITS(4),
    .PRESCALE(4),
    .BLANK_CYCLES(1),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digits_in(digits_in),
    .blank_in(blank_in),
    .dp_in(dp_in),
    .load(load),
    .dout(dout),
    .seg(seg),
    .dp(dp),
    .frame_done(frame_done)
  );

  // Advance one rising edge and sample 1 time unit later; k counts edges since release.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    logic exp_fd;
    digits_in = 16'h8888;
    blank_in  = 4'b0000;
    dp_in     = 4'b1111;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({dout, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_async dout/seg/dp/fd got %b/%h/%b/%b want 1111/7f/1/0",
               dout, seg, dp, frame_done);
    end
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      exp_fd = (k == 16) || (k == 32);
      tests_run++;
      if ({dout, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        fails++;
        $display("FAIL reset_dark k=%0d dout/seg/dp got %b/%h/%b want 1111/7f/1",
                 k, dout, seg, dp);
      end
      tests_run++;
      if (frame_done !== exp_fd) begin
        fails++;
        $display("FAIL reset_frame_done k=%0d got %b want %b", k, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_load_and_hold();
    logic [6:0] seg_a [4];
    logic [3:0] exp_dout;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fd;
    int         f, j, d, p;
    seg_a[0] = 7'h40; seg_a[1] = 7'h0E; seg_a[2] = 7'h12; seg_a[3] = 7'h08;
    digits_in = 16'hA5F0;
    blank_in  = 4'b0000;
    dp_in     = 4'b0100;
    apply_reset();
    for (int i = 0; i < 48; i++) begin
      if (k == 2)  load = 1'b1;
      if (k == 3)  load = 1'b0;
      if (k == 17) digits_in = 16'h1234;
      if (k == 19) load = 1'b1;
      if (k == 20) load = 1'b0;
      if (k == 24) digits_in = 16'h9999;
      step();
      f = (k - 1) / 16;
      j = (k - 1) % 16;
      d = j / 4;
      p = j % 4;
      if (f == 0 || p == 0) begin
        exp_dout = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_dout = ~(4'b0001 << d);
        exp_seg  = (f == 1) ? seg_a[d] : 7'h10;
        exp_dp   = (d != 2);
      end
      exp_fd = (k == 16) || (k == 32) || (k == 48);
      tests_run++;
      if ({dout, seg, dp} !== {exp_dout, exp_seg, exp_dp}) begin
        fails++;
        $display("FAIL load_display k=%0d dout/seg/dp got %b/%h/%b want %b/%h/%b",
                 k, dout, seg, dp, exp_dout, exp_seg, exp_dp);
      end
      tests_run++;
      if (frame_done !== exp_fd) begin
        fails++;
        $display("FAIL load_frame_done k=%0d got %b want %b", k, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] exp_dout;
    logic [6:0] exp_seg;
    int         f, j, d, p;
    digits_in = 16'h1234;
    blank_in  = 4'b1010;
    dp_in     = 4'b0000;
    apply_reset();
    load = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (k == 19) digits_in = 16'h0000;
      step();
      f = (k - 1) / 16;
      j = (k - 1) % 16;
      d = j / 4;
      p = j % 4;
      if (f == 0 || p == 0 || d == 1 || d == 3) begin
        exp_dout = 4'hF; exp_seg = 7'h7F;
      end else begin
        exp_dout = ~(4'b0001 << d);
        if (f == 1) exp_seg = (d == 0) ? 7'h19 : 7'h24;
        else        exp_seg = 7'h40;
      end
      tests_run++;
      if ({dout, seg, dp} !== {exp_dout, exp_seg, 1'b1}) begin
        fails++;
        $display("FAIL blank_display k=%0d dout/seg/dp got %b/%h/%b want %b/%h/1",
                 k, dout, seg, dp, exp_dout, exp_seg);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic exp_fd;
    digits_in = 16'h8888;
    blank_in  = 4'b0000;
    dp_in     = 4'b0000;
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      if (k == 2)  load = 1'b1;
      if (k == 3)  load = 1'b0;
      if (k == 19) begin load = 1'b1; digits_in = 16'h7777; end
      if (k == 20) load = 1'b0;
      step();
    end
    tests_run++;
    if ({dout, seg, dp} !== {4'b1101, 7'h00, 1'b1}) begin
      fails++;
      $display("FAIL midframe_before_reset dout/seg/dp got %b/%h/%b want 1101/00/1",
               dout, seg, dp);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({dout, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL midframe_async_off dout/seg/dp/fd got %b/%h/%b/%b want 1111/7f/1/0",
               dout, seg, dp, frame_done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      exp_fd = (k == 16) || (k == 32);
      tests_run++;
      if ({dout, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        fails++;
        $display("FAIL midframe_pending_dropped k=%0d dout/seg/dp got %b/%h/%b want 1111/7f/1",
                 k, dout, seg, dp);
      end
      tests_run++;
      if (frame_done !== exp_fd) begin
        fails++;
        $display("FAIL midframe_frame_done k=%0d got %b want %b", k, frame_done, exp_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_and_hold();
    test_blank();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Parametrised multiplexed seven-segment display scanner; the successor to the fixed four-digit display driver. It drives NUM_DIGITS common-anode digits from a packed nibble bus with full hex decoding (0-F), per-digit blanking, decimal points, a refresh prescaler and inter-digit ghost blanking. Display data is double-buffered and only swapped at frame boundaries, so the display never tears. It sits between the calculator/ALU result path and the board's segment/anode pins.

## Interface

- NUM_DIGITS, 4, number of multiplexed digits (1..16)
- PRESCALE, 4, clock cycles per digit slot (>= 2)
- BLANK_CYCLES, 1, cycles at the start of each slot with all digits off (0..PRESCALE-1)
- ACTIVE_LOW, 1, 1: dout/seg/dp are driven 0 = on; 0: driven 1 = on
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- digits_in  input  4*NUM_DIGITS  nibble i at [4i+3:4i] is shown on digit i
- blank_in  input  NUM_DIGITS  bit i = 1 keeps digit i dark
- dp_in  input  NUM_DIGITS  bit i = 1 lights the decimal point of digit i
- load  input  1  request to capture digits_in/blank_in/dp_in at the next frame boundary
- dout  output  NUM_DIGITS  digit enables, bit i selects digit i
- seg  output  7  segments, seg[0]=a ... seg[6]=g
- dp  output  1  decimal point
- frame_done  output  1  one-cycle pulse at each frame boundary

## Operation

- State: prescaler pcnt (0..PRESCALE-1), digit index idx (0..NUM_DIGITS-1), load_pend flag, and shadow registers sh_dig, sh_blank, sh_dp.
- pcnt increments every cycle. When pcnt = PRESCALE-1 it wraps to 0 and idx advances. When idx = NUM_DIGITS-1 it wraps to 0. For NUM_DIGITS = 1, idx stays 0.
- Frame boundary is the edge where idx wraps from NUM_DIGITS-1 to 0.
- On every frame boundary frame_done is 1 for the following cycle, otherwise 0.
- load = 1 on any edge sets load_pend.
- On a frame boundary with load_pend = 1, or with load = 1 on that same edge:
  - sh_dig/sh_blank/sh_dp capture the inputs present at that edge, not the values present when load was raised.
  - load_pend clears.
  - load held high continuously recaptures at every boundary.
- Output register, updated each edge from the current (idx, pcnt, shadows):
  - If pcnt < BLANK_CYCLES or sh_blank[idx] = 1: all dout off, seg all off, dp off.
  - Otherwise: only dout[idx] on, seg = hex pattern of sh_dig nibble idx, dp = sh_dp[idx].
- Hex patterns (lit segments):
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg
- ACTIVE_LOW inverts dout, seg and dp as a whole at the output register.

## Timing

- Reset (async, immediate): pcnt = 0, idx = 0, load_pend = 0, sh_dig = 0, sh_blank = all 1, sh_dp = 0, frame_done = 0, dout/seg/dp all off (all 1 when ACTIVE_LOW = 1). The display stays dark until the first load is taken.
- Output latency: one cycle from (idx, pcnt) to pins.
- Slot length is PRESCALE cycles, of which PRESCALE-BLANK_CYCLES are lit. Frame length is NUM_DIGITS*PRESCALE cycles.
- The first frame boundary after reset release is at edge NUM_DIGITS*PRESCALE.
- New shadow data is first visible in the slot for digit 0 of the next frame. A frame is never mixed between old and new data.
- Reset asserted mid-frame discards any pending load. Counting restarts from (0,0) on the first edge after release.
- No digit is ever on in two consecutive cycles with a different idx when BLANK_CYCLES >= 1.

## Test plan

Defaults throughout: NUM_DIGITS = 4, PRESCALE = 4, BLANK_CYCLES = 1, ACTIVE_LOW = 1.

- Reset, no load, run 40 cycles -> dout = 4'b1111 and seg = 7'h7F throughout; frame_done pulses at cycles 16 and 32 after release.
- Pulse load for 1 cycle at cycle 3 with digits_in = 16'hA5F0, blank_in = 0, dp_in = 4'b0100 -> capture at edge 16; then digit 0 shows 0 (seg = 7'h40), digit 1 shows F (7'h0E), digit 2 shows 5 (7'h12) with dp = 0, digit 3 shows A (7'h08).
- Each lit slot above -> exactly 1 blank cycle (dout = 1111) followed by 3 cycles of dout = 1110/1101/1011/0111 respectively.
- Change digits_in to 16'h1234 mid-frame without load -> display unchanged. Assert load at cycle 20 and change digits_in to 16'h9999 at cycle 25 -> frame from edge 32 shows 9999.
- blank_in = 4'b1010 captured -> digits 1 and 3 are never enabled; digits 0 and 2 are unaffected.
- Assert rst_n low at cycle 22 mid-frame with a load pending -> all outputs off immediately; after release the display stays dark and the pending data is not shown.
